// File: rtl/alu.sv
// 4-bit registered ALU: NAND, XOR, ADD, SUB with a signed-overflow flag.
// Result and flag are captured on the rising clock edge; reset clears both asynchronously.
module alu (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] ALU_In1,
    input  logic [3:0] ALU_In2,
    input  logic [1:0] Opcode,
    output logic [3:0] ALU_Out,
    output logic       Error
);

    typedef enum logic [1:0] {
        OpNand = 2'b00,
        OpXor  = 2'b01,
        OpAdd  = 2'b10,
        OpSub  = 2'b11
    } op_e;

    logic [3:0] out_d, out_q;
    logic       err_d, err_q;
    logic [3:0] sum;
    logic [3:0] diff;
    op_e        op;

    assign op   = op_e'(Opcode);
    assign sum  = ALU_In1 + ALU_In2;
    // Subtraction as A + ~B + 1 so the wrapped result matches two's-complement rules.
    assign diff = ALU_In1 + ~ALU_In2 + 4'd1;

    always_comb begin
        out_d = 4'b0000;
        err_d = 1'b0;
        unique case (op)
            OpNand: out_d = ~(ALU_In1 & ALU_In2);
            OpXor:  out_d = ALU_In1 ^ ALU_In2;
            OpAdd: begin
                out_d = sum;
                err_d = (ALU_In1[3] == ALU_In2[3]) && (sum[3] != ALU_In1[3]);
            end
            OpSub: begin
                out_d = diff;
                err_d = (ALU_In1[3] != ALU_In2[3]) && (diff[3] != ALU_In1[3]);
            end
            default: begin
                out_d = 4'b0000;
                err_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= 4'b0000;
            err_q <= 1'b0;
        end else begin
            out_q <= out_d;
            err_q <= err_d;
        end
    end

    assign ALU_Out = out_q;
    assign Error   = err_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases, latency, async reset, and a random sweep
// against an integer-arithmetic reference model.
module tb_alu;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic [3:0] alu_out;
    logic       error;

    int n_vec;
    int n_err;

    alu dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ALU_In1 (a),
        .ALU_In2 (b),
        .Opcode  (op),
        .ALU_Out (alu_out),
        .Error   (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: operands as signed integers, overflow when the true result leaves [-8,7].
    function automatic logic [4:0] model(input logic [3:0] x, input logic [3:0] y,
                                         input logic [1:0] o);
        int       sa;
        int       sb;
        int       r;
        logic [3:0] res;
        logic     ovf;
        sa  = int'($signed(x));
        sb  = int'($signed(y));
        ovf = 1'b0;
        res = 4'b0000;
        case (o)
            2'd0: res = ~(x & y);
            2'd1: res = x ^ y;
            default: begin
                r   = (o == 2'd2) ? sa + sb : sa - sb;
                ovf = (r > 7) || (r < -8);
                res = r[3:0];
            end
        endcase
        return {ovf, res};
    endfunction

    task automatic check(input string tag, input logic [3:0] exp_out, input logic exp_err);
        n_vec++;
        assert (alu_out === exp_out && error === exp_err) else begin
            n_err++;
            $error("FAIL %s: got out=%b err=%b, want out=%b err=%b",
                   tag, alu_out, error, exp_out, exp_err);
        end
    endtask

    task automatic drive(input logic [3:0] x, input logic [3:0] y, input logic [1:0] o);
        @(negedge clk);
        a  = x;
        b  = y;
        op = o;
    endtask

    task automatic step(input string tag, input logic [3:0] x, input logic [3:0] y,
                        input logic [1:0] o, input logic [3:0] exp_out, input logic exp_err);
        drive(x, y, o);
        @(posedge clk);
        #1;
        check(tag, exp_out, exp_err);
    endtask

    initial begin
        logic [4:0] exp;
        n_vec = 0;
        n_err = 0;
        a     = 4'd0;
        b     = 4'd0;
        op    = 2'd0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2 check("reset_async", 4'b0000, 1'b0);
        repeat (2) @(posedge clk);
        #1 check("reset_hold", 4'b0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        step("nand",      4'b0101, 4'b0011, 2'd0, 4'b1110, 1'b0);
        step("xor",       4'b0110, 4'b0011, 2'd1, 4'b0101, 1'b0);
        step("add_3p2",   4'd3,    4'd2,    2'd2, 4'b0101, 1'b0);
        step("add_7p1",   4'd7,    4'd1,    2'd2, 4'b1000, 1'b1);
        step("add_m8m1",  4'b1000, 4'b1111, 2'd2, 4'b0111, 1'b1);
        step("add_m3p2",  4'b1101, 4'd2,    2'd2, 4'b1111, 1'b0);
        step("sub_3m5",   4'd3,    4'd5,    2'd3, 4'b1110, 1'b0);
        step("sub_7mm1",  4'd7,    4'b1111, 2'd3, 4'b1000, 1'b1);
        step("sub_m8m1",  4'b1000, 4'd1,    2'd3, 4'b0111, 1'b1);
        step("sub_m8mm8", 4'b1000, 4'b1000, 2'd3, 4'b0000, 1'b0);
        step("sub_0mm8",  4'd0,    4'b1000, 2'd3, 4'b1000, 1'b1);
        step("err_clear", 4'd1,    4'd1,    2'd2, 4'b0010, 1'b0);

        // Inputs change between edges; outputs must hold until the next rising edge.
        step("lat_first", 4'd7, 4'd1, 2'd2, 4'b1000, 1'b1);
        drive(4'd3, 4'd5, 2'd3);
        #2 check("lat_hold", 4'b1000, 1'b1);
        @(posedge clk);
        #1 check("lat_update", 4'b1110, 1'b0);

        // Reset asserted between edges with a pending operation.
        step("pre_reset", 4'd7, 4'd1, 2'd2, 4'b1000, 1'b1);
        drive(4'd6, 4'd6, 2'd2);
        #2 rst_n = 1'b0;
        #1 check("rst_mid", 4'b0000, 1'b0);
        @(posedge clk);
        #1 check("rst_mid_hold", 4'b0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_reset", 4'd3, 4'd2, 2'd2, 4'b0101, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            logic [3:0] ra;
            logic [3:0] rb;
            logic [1:0] ro;
            ra  = 4'($urandom_range(15));
            rb  = 4'($urandom_range(15));
            ro  = 2'($urandom_range(3));
            exp = model(ra, rb, ro);
            step("random", ra, rb, ro, exp[3:0], exp[4]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
